// File: rtl/muldiv_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op and state
// encodings, default multiply latency and small op-class helpers.
package muldiv_hilo_pkg;

    localparam int MUL_LAT_DEFAULT = 2;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MUL   = 3'b110,
        OP_NONE  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MULW = 2'b01,
        ST_DIVW = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Ops that occupy the unit for more than the accept cycle (and stall EX).
    function automatic logic is_long_op(input op_e o);
        return o inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MUL};
    endfunction

    function automatic logic is_div_op(input op_e o);
        return o inside {OP_DIV, OP_DIVU};
    endfunction

endpackage

// File: rtl/muldiv_hilo_if.sv
// EX-stage connection of the multiply/divide unit: operands and control in,
// stall request, completion pulse and result words out.
interface muldiv_hilo_if;
    import muldiv_hilo_pkg::*;

    logic        start;
    op_e         op;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        rhl_sel;
    logic        busy;
    logic        done;
    logic [31:0] RHLOut;
    logic [31:0] MULOut;

    modport master (
        output start, op, A, B, flush, rhl_sel,
        input  busy, done, RHLOut, MULOut
    );

    modport slave (
        input  start, op, A, B, flush, rhl_sel,
        output busy, done, RHLOut, MULOut
    );

endinterface

// File: rtl/muldiv_hilo_div_iter.sv
// div_iter: unsigned radix-2 restoring divider, one quotient bit per step.
// Sign handling and divide-by-zero results are the caller's business.
module muldiv_hilo_div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    logic [31:0] quo_reg, rem_reg, dvs_reg;
    logic [31:0] quo_next, rem_next;
    logic [32:0] shifted, trial;

    // One restoring step: shift in the next dividend bit, try subtracting.
    always_comb begin
        shifted = {rem_reg, quo_reg[31]};
        trial   = shifted - {1'b0, dvs_reg};
        if (!trial[32]) begin
            rem_next = trial[31:0];
            quo_next = {quo_reg[30:0], 1'b1};
        end else begin
            rem_next = shifted[31:0];
            quo_next = {quo_reg[30:0], 1'b0};
        end
    end

    // Outputs include the step taken this cycle, so the caller can commit
    // the result on the same edge as the final iteration.
    assign quotient  = quo_next;
    assign remainder = rem_next;

    // Load operands, then advance one bit per step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_reg <= '0;
            rem_reg <= '0;
            dvs_reg <= '0;
        end else if (load) begin
            quo_reg <= dividend;
            rem_reg <= '0;
            dvs_reg <= divisor;
        end else if (step) begin
            quo_reg <= quo_next;
            rem_reg <= rem_next;
        end
    end

endmodule

// File: rtl/muldiv_hilo.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// Multiplies run through a MUL_LAT-deep pipeline, divides take 32 iterations;
// busy stalls EX while an operation is in flight.
module muldiv_hilo
    import muldiv_hilo_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_hilo_if.slave io
);
    localparam int PIPE_D = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

    state_e      state_reg;
    op_e         op_reg;
    logic [4:0]  cnt_reg;
    logic [31:0] hi_reg, lo_reg, mul_out_reg, a_reg;
    logic        b_zero_reg, q_neg_reg, r_neg_reg;

    logic        accept, signed_div, div_load, div_step;
    logic [31:0] mag_a, mag_b, div_q, div_r;
    logic [63:0] prod_comb, mul_final;

    assign accept     = io.start && !io.flush && (state_reg == ST_IDLE);
    assign signed_div = (io.op == OP_DIV);
    assign mag_a      = (signed_div && io.A[31]) ? -io.A : io.A;
    assign mag_b      = (signed_div && io.B[31]) ? -io.B : io.B;
    assign div_load   = accept && is_div_op(io.op);
    assign div_step   = (state_reg == ST_DIVW);

    // Full 64-bit product from the live operands; retiming left to synthesis.
    always_comb begin
        if (io.op == OP_MULTU) begin
            prod_comb = {32'd0, io.A} * {32'd0, io.B};
        end else begin
            prod_comb = $signed({{32{io.A[31]}}, io.A}) * $signed({{32{io.B[31]}}, io.B});
        end
    end

    // Product pipeline; HI/LO (or MULOut) act as the final stage.
    for (genvar gi = 0; gi < PIPE_D; gi++) begin : g_pipe
        logic [63:0] prod_reg;
        if (gi == 0) begin : g_first
            always_ff @(posedge clk) prod_reg <= prod_comb;
        end else begin : g_rest
            always_ff @(posedge clk) prod_reg <= g_pipe[gi-1].prod_reg;
        end
    end

    assign mul_final = (MUL_LAT == 1) ? prod_comb : g_pipe[PIPE_D-1].prod_reg;

    muldiv_hilo_div_iter u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .step      (div_step),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // Control FSM plus HI/LO/MULOut commit; flush aborts without writing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            op_reg      <= OP_NONE;
            cnt_reg     <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            mul_out_reg <= '0;
            a_reg       <= '0;
            b_zero_reg  <= 1'b0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
        end else if (io.flush) begin
            state_reg <= ST_IDLE;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg     <= io.op;
                        a_reg      <= io.A;
                        b_zero_reg <= (io.B == 32'd0);
                        q_neg_reg  <= signed_div && (io.A[31] ^ io.B[31]);
                        r_neg_reg  <= signed_div && io.A[31];
                        unique case (io.op)
                            OP_MTHI: hi_reg <= io.A;
                            OP_MTLO: lo_reg <= io.A;
                            OP_MULT, OP_MULTU, OP_MUL: begin
                                if (MUL_LAT == 1) begin
                                    if (io.op == OP_MUL) begin
                                        mul_out_reg <= mul_final[31:0];
                                    end else begin
                                        hi_reg <= mul_final[63:32];
                                        lo_reg <= mul_final[31:0];
                                    end
                                    state_reg <= ST_DONE;
                                end else begin
                                    state_reg <= ST_MULW;
                                    cnt_reg   <= 5'd1;
                                end
                            end
                            OP_DIV, OP_DIVU: begin
                                state_reg <= ST_DIVW;
                                cnt_reg   <= 5'd0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MULW: begin
                    if (cnt_reg == 5'(MUL_LAT - 1)) begin
                        if (op_reg == OP_MUL) begin
                            mul_out_reg <= mul_final[31:0];
                        end else begin
                            hi_reg <= mul_final[63:32];
                            lo_reg <= mul_final[31:0];
                        end
                        state_reg <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 5'd1;
                    end
                end
                ST_DIVW: begin
                    if (cnt_reg == 5'd31) begin
                        lo_reg    <= b_zero_reg ? 32'hFFFF_FFFF : (q_neg_reg ? -div_q : div_q);
                        hi_reg    <= b_zero_reg ? a_reg : (r_neg_reg ? -div_r : div_r);
                        state_reg <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 5'd1;
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign io.busy   = !rst && !io.flush &&
                       ((state_reg == ST_MULW) || (state_reg == ST_DIVW) ||
                        ((state_reg == ST_IDLE) && io.start && is_long_op(io.op)));
    assign io.done   = (state_reg == ST_DONE);
    assign io.RHLOut = io.rhl_sel ? hi_reg : lo_reg;
    assign io.MULOut = mul_out_reg;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Bench for muldiv_hilo: arithmetic reference model with a per-cycle compare,
// plus directed operations with hand-computed results.
module tb_muldiv_hilo;
    import muldiv_hilo_pkg::*;

    localparam int MUL_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_hilo_if mif();

    muldiv_hilo #(.MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .io  (mif.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic long_op(input op_e o);
        return o inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MUL};
    endfunction

    // Reference {HI, LO} from plain arithmetic.
    function automatic logic [63:0] golden(input op_e o, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int sa, sb, q, r;
        sa = a;
        sb = b;
        case (o)
            OP_MULT, OP_MUL: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            OP_MULTU: begin
                p = longint'({32'd0, a}) * longint'({32'd0, b});
                return p;
            end
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            OP_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Model: m_cnt = cycles left before DONE, m_done = DONE cycle.
    logic [31:0] m_hi = '0, m_lo = '0, m_mul = '0, p_hi = '0, p_lo = '0;
    op_e         p_op = OP_NONE;
    int          m_cnt = 0;
    logic        m_done = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        logic [63:0] g;
        if (rst) begin
            m_hi <= '0; m_lo <= '0; m_mul <= '0; m_cnt <= 0; m_done <= 1'b0;
        end else if (mif.flush) begin
            m_cnt <= 0; m_done <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end else if (m_cnt == 1) begin
            m_cnt  <= 0;
            m_done <= 1'b1;
            if (p_op == OP_MUL) m_mul <= p_lo;
            else begin m_hi <= p_hi; m_lo <= p_lo; end
        end else if (mif.start) begin
            g = golden(mif.op, mif.A, mif.B);
            if (mif.op == OP_MTHI) m_hi <= mif.A;
            else if (mif.op == OP_MTLO) m_lo <= mif.A;
            else if (long_op(mif.op)) begin
                p_op <= mif.op;
                p_hi <= g[63:32];
                p_lo <= g[31:0];
                if (mif.op inside {OP_DIV, OP_DIVU}) m_cnt <= 32;
                else if (MUL_LAT > 1) m_cnt <= MUL_LAT - 1;
                else begin
                    m_done <= 1'b1;
                    if (mif.op == OP_MUL) m_mul <= g[31:0];
                    else begin m_hi <= g[63:32]; m_lo <= g[31:0]; end
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin : compare
        logic exp_busy;
        exp_busy = !rst && !mif.flush &&
                   ((m_cnt > 0) || (!m_done && mif.start && long_op(mif.op)));
        check("cmp_busy",   {31'd0, mif.busy}, {31'd0, exp_busy});
        check("cmp_done",   {31'd0, mif.done}, {31'd0, m_done});
        check("cmp_rhlout", mif.RHLOut, mif.rhl_sel ? m_hi : m_lo);
        check("cmp_mulout", mif.MULOut, m_mul);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a long op, holding start until the DONE cycle has passed.
    task automatic run_op(input op_e o, input logic [31:0] a_v, input logic [31:0] b_v,
                          output int nbusy, output int tdone);
        mif.start = 1'b1; mif.op = o; mif.A = a_v; mif.B = b_v;
        nbusy = 0;
        tdone = -1;
        for (int c = 0; c < 40 && tdone < 0; c++) begin
            #2;
            if (mif.busy) nbusy++;
            if (mif.done) tdone = c;
            tick();
        end
        mif.start = 1'b0; mif.op = OP_NONE;
        $display("op %s A=0x%08h B=0x%08h busy_cycles=%0d done_cycle=%0d", o.name(), a_v, b_v, nbusy, tdone);
    endtask

    task automatic run_mt(input op_e o, input logic [31:0] a_v);
        mif.start = 1'b1; mif.op = o; mif.A = a_v;
        tick();
        mif.start = 1'b0; mif.op = OP_NONE;
        $display("op %s A=0x%08h", o.name(), a_v);
    endtask

    task automatic read_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        mif.rhl_sel = 1'b1; #1;
        check({name, "_hi"}, mif.RHLOut, exp_hi);
        mif.rhl_sel = 1'b0; #1;
        check({name, "_lo"}, mif.RHLOut, exp_lo);
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int nb, td, nd;
        mif.start = 1'b0; mif.op = OP_NONE; mif.A = '0; mif.B = '0;
        mif.flush = 1'b0; mif.rhl_sel = 1'b0;
        repeat (2) tick();
        check("rst_busy",   {31'd0, mif.busy}, 32'd0);
        check("rst_done",   {31'd0, mif.done}, 32'd0);
        check("rst_mulout", mif.MULOut, 32'd0);
        read_hilo("rst", 32'd0, 32'd0);
        rst = 1'b0;
        tick();

        run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, nb, td);
        check("mult_busy_cycles", nb, 2);
        check("mult_done_cycle",  td, 2);
        read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, nb, td);
        read_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, td);
        read_hilo("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, nb, td);
        check("div_busy_cycles", nb, 33);
        check("div_done_cycle",  td, 33);
        read_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, nb, td);
        read_hilo("div_negdivisor", 32'd1, 32'hFFFF_FFFD);

        run_op(OP_DIVU, 32'd100, 32'd7, nb, td);
        read_hilo("divu", 32'd2, 32'd14);

        run_op(OP_DIVU, 32'h1234, 32'd0, nb, td);
        read_hilo("divu_by0", 32'h1234, 32'hFFFF_FFFF);

        run_op(OP_DIV, 32'hFFFF_FFF8, 32'd0, nb, td);
        read_hilo("div_by0", 32'hFFFF_FFF8, 32'hFFFF_FFFF);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb, td);
        read_hilo("div_ovf", 32'd0, 32'h8000_0000);

        // Flush in cycle 10 of a divide.
        run_mt(OP_MTHI, 32'h55);
        run_mt(OP_MTLO, 32'h55);
        mif.start = 1'b1; mif.op = OP_DIV; mif.A = 32'd1000; mif.B = 32'd3;
        nb = 0;
        for (int c = 0; c < 10; c++) begin
            #2;
            if (mif.busy) nb++;
            tick();
        end
        check("flush_busy_before", nb, 10);
        mif.flush = 1'b1; #2;
        check("flush_busy_c10", {31'd0, mif.busy}, 32'd0);
        tick();
        mif.flush = 1'b0; mif.start = 1'b0; mif.op = OP_NONE; #2;
        check("flush_c11_busy", {31'd0, mif.busy}, 32'd0);
        check("flush_c11_done", {31'd0, mif.done}, 32'd0);
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (mif.done) nd++;
        end
        check("flush_no_done", nd, 0);
        $display("flush DIV at cycle 10");
        read_hilo("flush", 32'h55, 32'h55);

        // MTHI together with flush is dropped.
        mif.start = 1'b1; mif.op = OP_MTHI; mif.A = 32'hDEAD; mif.flush = 1'b1;
        tick();
        mif.start = 1'b0; mif.op = OP_NONE; mif.flush = 1'b0;
        $display("op OP_MTHI A=0x0000dead with flush");
        read_hilo("mthi_flush", 32'h55, 32'h55);

        // MUL with start held through DONE; exactly one acceptance.
        run_mt(OP_MTLO, 32'hA5A5_A5A5);
        run_op(OP_MUL, 32'd3, 32'd5, nb, td);
        check("mul_done_cycle", td, 2);
        check("mul_mulout", mif.MULOut, 32'd15);
        read_hilo("mul_keep", 32'h55, 32'hA5A5_A5A5);
        nd = 0;
        for (int c = 0; c < 4; c++) begin
            if (mif.done || mif.busy) nd++;
            tick();
        end
        check("mul_single_accept", nd, 0);

        run_op(OP_MUL, 32'hFFFF_FFFD, 32'd7, nb, td);
        check("mul_neg_mulout", mif.MULOut, 32'hFFFF_FFEB);

        // Reset in the middle of a MULT.
        mif.start = 1'b1; mif.op = OP_MULT; mif.A = 32'd7; mif.B = 32'd9;
        tick();
        #2 rst = 1'b1;
        #1;
        check("rstmid_busy",   {31'd0, mif.busy}, 32'd0);
        check("rstmid_done",   {31'd0, mif.done}, 32'd0);
        check("rstmid_mulout", mif.MULOut, 32'd0);
        mif.rhl_sel = 1'b1; #0.5;
        check("rstmid_hi", mif.RHLOut, 32'd0);
        mif.rhl_sel = 1'b0; #0.5;
        check("rstmid_lo", mif.RHLOut, 32'd0);
        mif.start = 1'b0; mif.op = OP_NONE;
        $display("reset asserted mid-MULT");
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_op(OP_MULT, 32'd7, 32'd9, nb, td);
        check("post_rst_done_cycle", td, 2);
        read_hilo("post_rst", 32'd0, 32'd63);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
